// File: rtl/countdown_timer_pkg.sv
// Shared timer package.
// Holds the controller state encoding and the default seconds-count width,
// so the timer and anything observing its state agree on both.
package countdown_timer_pkg;

    // Default bit width of the seconds count.
    localparam int TIMER_WIDTH_DEFAULT = 4;

    // IDLE     : nothing to count, remaining holds its last value
    // LOAD     : one-cycle settle after a start; the divider is being re-phased
    // COUNTING : decrementing remaining on each one-second tick
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        COUNTING = 2'd2
    } timer_state_e;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer.sv
// countdown_timer
// Seconds countdown controller. It sits beside a 1 Hz divider: div_restart
// feeds the divider's start input, and the divider's tick comes back as
// one_hz_enable. Every output is registered.
//
// Ports
//   clock         : system clock, rising edge
//   reset         : synchronous active-high reset, beats start_timer
//   start_timer   : one-cycle request to load value and begin counting
//   value         : countdown length in seconds, sampled with start_timer
//   one_hz_enable : one-cycle-per-second tick from the divider
//   div_restart   : one-cycle pulse that re-zeroes the divider phase
//   busy          : high while counting
//   remaining     : seconds left
//   expired       : one-cycle pulse when the count reaches zero
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_timer,
    input  logic [WIDTH-1:0] value,
    input  logic             one_hz_enable,
    output logic             div_restart,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             expired
);

    timer_state_e     state, state_nxt;
    logic [WIDTH-1:0] remaining_nxt;
    logic             expired_nxt;
    logic             div_restart_nxt;
    logic             busy_nxt;

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            busy        <= 1'b0;
            expired     <= 1'b0;
            div_restart <= 1'b0;
        end else begin
            state       <= state_nxt;
            remaining   <= remaining_nxt;
            busy        <= busy_nxt;
            expired     <= expired_nxt;
            div_restart <= div_restart_nxt;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_nxt       = state;
        remaining_nxt   = remaining;
        expired_nxt     = 1'b0;
        div_restart_nxt = 1'b0;

        if (start_timer) begin
            // A start always wins: reload, drop any tick, and re-phase the
            // divider so the first second is a full second.
            state_nxt       = LOAD;
            remaining_nxt   = value;
            div_restart_nxt = 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    // Any tick seen here is a stale one from the old divider
                    // phase, so it is deliberately not looked at.
                    if (remaining != '0) begin
                        state_nxt = COUNTING;
                    end else begin
                        state_nxt   = IDLE;
                        expired_nxt = 1'b1;
                    end
                end
                COUNTING: begin
                    if (one_hz_enable) begin
                        if (remaining > WIDTH'(1)) begin
                            remaining_nxt = remaining - WIDTH'(1);
                        end else begin
                            // Last second: finish at zero instead of
                            // decrementing, so the count can never wrap.
                            remaining_nxt = '0;
                            expired_nxt   = 1'b1;
                            state_nxt     = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_nxt = (state_nxt == COUNTING);
    end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios followed by a long random
// run, all compared each cycle against a behavioural model of the timer.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start_timer;
    logic [W-1:0] value;
    logic         one_hz_enable;
    logic         div_restart;
    logic         busy;
    logic [W-1:0] remaining;
    logic         expired;

    int checks = 0;
    int errors = 0;

    // Model: seconds left, whether a load is settling, whether counting.
    int m_rem     = 0;
    bit m_loading = 0;
    bit m_active  = 0;
    bit m_exp     = 0;
    bit m_dr      = 0;

    int exp_seen  = 0;
    int dr_seen   = 0;
    int busy_seen = 0;

    always #5 clock = ~clock;

    countdown_timer #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .start_timer   (start_timer),
        .value         (value),
        .one_hz_enable (one_hz_enable),
        .div_restart   (div_restart),
        .busy          (busy),
        .remaining     (remaining),
        .expired       (expired)
    );

    task automatic chk(input string tag, input int obs, input int want);
        checks++;
        if (obs != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, want, $time);
        end
    endtask

    // One clock: apply inputs, advance the model on the edge, compare 1 time
    // unit later.
    task automatic step(input bit s, input int v, input bit t, input bit r);
        reset         = r;
        start_timer   = s;
        value         = W'(v);
        one_hz_enable = t;
        @(posedge clock);
        if (r) begin
            m_rem = 0; m_loading = 0; m_active = 0; m_exp = 0; m_dr = 0;
        end else if (s) begin
            m_rem = v; m_loading = 1; m_active = 0; m_exp = 0; m_dr = 1;
        end else if (m_loading) begin
            m_loading = 0; m_dr = 0;
            m_exp     = (m_rem == 0);
            m_active  = (m_rem != 0);
        end else if (m_active && t) begin
            m_rem    = m_rem - 1;
            m_exp    = (m_rem == 0);
            m_active = (m_rem != 0);
            m_dr     = 0;
        end else begin
            m_exp = 0; m_dr = 0;
        end
        #1;
        chk("remaining",   int'(remaining),   m_rem);
        chk("busy",        int'(busy),        int'(m_active));
        chk("expired",     int'(expired),     int'(m_exp));
        chk("div_restart", int'(div_restart), int'(m_dr));
        exp_seen  += int'(expired);
        dr_seen   += int'(div_restart);
        busy_seen += int'(busy);
    endtask

    task automatic idle_cycles(input int n, input bit t);
        for (int i = 0; i < n; i++) step(0, 0, t, 0);
    endtask

    // Tick once every 10 cycles, n times.
    task automatic ticks10(input int n);
        for (int i = 0; i < n; i++) begin
            idle_cycles(9, 0);
            step(0, 0, 1, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start_timer = 1'b0; value = '0; one_hz_enable = 1'b0;

        // Reset state.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Count from 3 with ticks every 10 cycles.
        exp_seen = 0;
        step(1, 3, 0, 0);
        ticks10(3);
        idle_cycles(3, 0);
        chk("cnt3_expired_pulses", exp_seen, 1);
        chk("cnt3_final_rem", int'(remaining), 0);

        // Zero-length countdown: expired straight out of LOAD, no busy.
        exp_seen = 0; dr_seen = 0; busy_seen = 0;
        step(1, 0, 0, 0);
        idle_cycles(4, 0);
        chk("zero_expired_pulses", exp_seen, 1);
        chk("zero_dr_pulses", dr_seen, 1);
        chk("zero_busy_cycles", busy_seen, 0);

        // Start with a tick in the same cycle, then a tick during LOAD.
        step(1, 5, 1, 0);
        step(0, 0, 1, 0);
        chk("start_tick_rem", int'(remaining), 5);
        idle_cycles(2, 0);

        // Restart mid-count from 4 with 7.
        step(1, 4, 0, 0);
        ticks10(2);
        exp_seen = 0;
        step(1, 7, 0, 0);
        ticks10(6);
        chk("restart_no_early_expire", exp_seen, 0);
        ticks10(1);
        idle_cycles(2, 0);
        chk("restart_expire_after_7", exp_seen, 1);

        // Reset mid-count from 6.
        step(1, 6, 0, 0);
        ticks10(1);
        exp_seen = 0;
        step(0, 0, 0, 1);
        ticks10(3);
        chk("reset_abort_no_expire", exp_seen, 0);

        // Idle with ticks only.
        exp_seen = 0; busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            idle_cycles(2, 0);
            step(0, 0, 1, 0);
        end
        chk("idle_ticks_expired", exp_seen, 0);
        chk("idle_ticks_busy", busy_seen, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 24) == 0,
                 int'($urandom_range(0, (1 << W) - 1)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the bit width of the seconds count.
REQ-002 SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port start_timer, input, 1, a one-cycle request to load value and begin counting.
REQ-005 SHALL have port value, input, WIDTH, the countdown length in seconds, sampled only when start_timer is high.
REQ-006 SHALL have port one_hz_enable, input, 1, the one-cycle-per-second tick from the divider.
REQ-007 SHALL have port div_restart, output, 1, a one-cycle pulse that zeroes the divider phase.
REQ-008 SHALL have port busy, output, 1, high while in COUNTING.
REQ-009 SHALL have port remaining, output, WIDTH, the seconds left.
REQ-010 SHALL have port expired, output, 1, a one-cycle pulse when the countdown reaches zero.

Function
REQ-011 SHALL implement the states IDLE, LOAD and COUNTING.
REQ-012 In any state, start_timer SHALL cause the next state to be LOAD, remaining <= value, and div_restart = 1 for exactly that one cycle.
REQ-013 LOAD SHALL last one cycle; from LOAD the block SHALL go to COUNTING if remaining != 0. If remaining == 0 it SHALL go to IDLE and pulse expired in the same cycle as that transition.
REQ-014 In LOAD, one_hz_enable SHALL be ignored, so the divider's stale tick is discarded.
REQ-015 In COUNTING, one_hz_enable with remaining > 1 SHALL decrement remaining by 1 and stay in COUNTING.
REQ-016 In COUNTING, one_hz_enable with remaining == 1 SHALL:
- set remaining to 0;
- assert expired for exactly one cycle;
- move to IDLE.
REQ-017 In IDLE, one_hz_enable SHALL be ignored and remaining SHALL hold.
REQ-018 start_timer together with one_hz_enable in the same cycle SHALL give priority to start_timer (reload, no decrement, no expired).
REQ-019 start_timer during COUNTING SHALL restart from the new value; the old count SHALL be discarded with no expired pulse.
REQ-020 remaining SHALL never wrap; a decrement below 0 is unreachable by construction.
REQ-021 All outputs SHALL be registered; expired and div_restart SHALL be high for at most one consecutive cycle per event.
REQ-022 Latency SHALL be:
- start_timer to div_restart: 1 cycle;
- expiring tick to expired: 1 cycle.

Reset
REQ-023 reset SHALL take priority over start_timer.
REQ-024 reset SHALL force state = IDLE, remaining = 0, busy = 0, expired = 0 and div_restart = 0 on the next edge.
REQ-025 reset asserted mid-count SHALL abort the count with no expired pulse.
REQ-026 No initial blocks SHALL be relied on for functional reset values.

Structure
REQ-027 A shared timer package SHALL hold the state enum typedef (IDLE, LOAD, COUNTING) and the WIDTH default constant.
REQ-028 The block SHALL be a single module with no sub-module; the divider is instantiated beside it at top level, with div_restart driving the divider's start_timer input and one_hz_enable coming back from it.

Verification
REQ-029 Reset, then start_timer with value = 3, then ticks every 10 cycles -> remaining goes 3, 2, 1, 0; expired is one cycle, 1 cycle after the third tick; busy falls with it.
REQ-030 start_timer with value = 0 -> div_restart pulse, then expired pulse in the LOAD-exit cycle; busy never asserts.
REQ-031 start_timer with value = 5 and one_hz_enable in the same cycle -> remaining = 5 with no decrement; a tick in LOAD is ignored.
REQ-032 Count from 4; after 2 ticks, start_timer with value = 7 -> remaining = 7, div_restart pulses, no expired until 7 further ticks.
REQ-033 Count from 6; after 1 tick assert reset -> remaining = 0, IDLE, no expired; later ticks have no effect.
REQ-034 IDLE with 20 ticks and no start -> remaining, expired and busy unchanged at 0.
